// File: rtl/riscv_mem_io_responder_if.sv
// Memory request/response bus between the multicycle core (master) and the
// memory/MMIO responder (slave).
interface riscv_mem_io_responder_if;
  logic        MEM_EN;
  logic        MEM_WE;
  logic [31:0] MAR;
  logic [31:0] MDR_out;
  logic [3:0]  MEM_BE;
  logic [31:0] data_mem_R;
  logic        MEM_READY;
  logic        MEM_BUSY;

  modport master (
    output MEM_EN, MEM_WE, MAR, MDR_out, MEM_BE,
    input  data_mem_R, MEM_READY, MEM_BUSY
  );

  modport slave (
    input  MEM_EN, MEM_WE, MAR, MDR_out, MEM_BE,
    output data_mem_R, MEM_READY, MEM_BUSY
  );
endinterface

// File: rtl/riscv_mem_io_responder.sv
// Memory/MMIO responder for the multicycle RISC-V core: word RAM plus SW/LED/HEX
// registers, fixed wait-state latency. Optional macro RISCV_MEM_ACCESS_ERR_EN enables ERR.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no request outstanding; MEM_EN accepted here only
// ST_WAIT | request captured, wait-state counter running, MEM_BUSY=1
// ST_RESP | write committed / read data valid, MEM_READY pulse
module riscv_mem_io_responder #(
  parameter int          RAM_WORDS   = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic                           Clk,
  input  logic                           Reset,
  riscv_mem_io_responder_if.slave        bus,
  input  logic [9:0]                     SW,
  output logic [9:0]                     LED,
  output logic [23:0]                    HEX_VAL,
  output logic                           ERR
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] SW_ADDR   = MMIO_BASE;
  localparam logic [31:0] LED_ADDR  = MMIO_BASE + 32'd4;
  localparam logic [31:0] HEX_ADDR  = MMIO_BASE + 32'd8;
  localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [2:0]  WAIT_LOAD = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt;
  logic        accept, go_resp;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, word_addr;
  logic [3:0]  cur_be;

  logic        hit_ram, hit_sw, hit_led, hit_hex;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_word, ram_merged, rdata_nxt;

  logic [9:0]  sw_meta, sw_sync;
  logic [9:0]  led_q;
  logic [23:0] hex_q;
  logic [31:0] rdata_q;
  logic        mem_ready, mem_busy;

  assign accept  = (state == ST_IDLE) && bus.MEM_EN;
  assign go_resp = (state_nxt == ST_RESP);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.MEM_EN) state_nxt = HAS_WAIT ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wait_cnt == 3'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_ready = 1'b0;
    mem_busy  = 1'b0;
    case (state)
      ST_WAIT: mem_busy  = 1'b1;
      ST_RESP: mem_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset)                          wait_cnt <= 3'd0;
    else if (accept)                    wait_cnt <= WAIT_LOAD;
    else if (state == ST_WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      we_q    <= bus.MEM_WE;
      addr_q  <= bus.MAR;
      wdata_q <= bus.MDR_out;
      be_q    <= bus.MEM_BE;
    end
  end

  // With zero wait states the response is produced straight from the live request.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = bus.MEM_WE;
      cur_addr  = bus.MAR;
      cur_wdata = bus.MDR_out;
      cur_be    = bus.MEM_BE;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  assign word_addr = {cur_addr[31:2], 2'b00};
  assign hit_ram   = (cur_addr < RAM_BYTES);
  assign hit_sw    = (word_addr == SW_ADDR);
  assign hit_led   = (word_addr == LED_ADDR);
  assign hit_hex   = (word_addr == HEX_ADDR);
  assign ram_idx   = cur_addr[IDX_W+1:2];
  assign ram_word  = ram[ram_idx];

  always_comb begin
    ram_merged = ram_word;
    for (int b = 0; b < 4; b++)
      if (cur_be[b]) ram_merged[8*b +: 8] = cur_wdata[8*b +: 8];
  end

  // Value returned to the core: the location's contents after any write.
  always_comb begin
    rdata_nxt = 32'd0;
    if (hit_ram)
      rdata_nxt = cur_we ? ram_merged : ram_word;
    else if (hit_sw)
      rdata_nxt = {22'd0, sw_sync};
    else if (hit_led)
      rdata_nxt = {22'd0, (cur_we && cur_be != 4'd0) ? cur_wdata[9:0] : led_q};
    else if (hit_hex)
      rdata_nxt = {8'd0, (cur_we && cur_be != 4'd0) ? cur_wdata[23:0] : hex_q};
  end

  always_ff @(posedge Clk) begin
    if (!Reset && go_resp && cur_we && hit_ram)
      for (int b = 0; b < 4; b++)
        if (cur_be[b]) ram[ram_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_q <= 32'd0;
      led_q   <= 10'd0;
      hex_q   <= 24'd0;
    end else if (go_resp) begin
      rdata_q <= rdata_nxt;
      if (cur_we && cur_be != 4'd0 && hit_led) led_q <= cur_wdata[9:0];
      if (cur_we && cur_be != 4'd0 && hit_hex) hex_q <= cur_wdata[23:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_meta <= 10'd0;
      sw_sync <= 10'd0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

`ifdef RISCV_MEM_ACCESS_ERR_EN
  logic err_hit, err_q;
  assign err_hit = !(hit_ram || hit_sw || hit_led || hit_hex) ||
                   ((cur_addr[1:0] != 2'b00) && (cur_be == 4'hF));
  always_ff @(posedge Clk) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= go_resp && err_hit;
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign bus.data_mem_R = rdata_q;
  assign bus.MEM_READY  = mem_ready;
  assign bus.MEM_BUSY   = mem_busy;
  assign LED            = led_q;
  assign HEX_VAL        = hex_q;

endmodule
